// File: rtl/mult_cmd_sequencer_if.sv
// Command, multiplier and response signals of the Booth multiplier front-end.
// slave is the sequencer side; master is the command source / multiplier / consumer side.
interface mult_cmd_sequencer_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [15:0]      cmd_a;
  logic [15:0]      cmd_b;
  logic [1:0]       cmd_mode;
  logic [TAG_W-1:0] cmd_tag;

  logic [15:0]      mul_multiplicand;
  logic [15:0]      mul_multiplier;
  logic [1:0]       mul_cm;
  logic             mul_enable;
  logic [31:0]      mul_product;
  logic             mul_valid;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_product;
  logic [TAG_W-1:0] rsp_tag;
  logic [1:0]       rsp_err;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_mode, cmd_tag,
    input  mul_product, mul_valid,
    input  rsp_ready,
    output cmd_ready,
    output mul_multiplicand, mul_multiplier, mul_cm, mul_enable,
    output rsp_valid, rsp_product, rsp_tag, rsp_err
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_mode, cmd_tag,
    output mul_product, mul_valid,
    output rsp_ready,
    input  cmd_ready,
    input  mul_multiplicand, mul_multiplier, mul_cm, mul_enable,
    input  rsp_valid, rsp_product, rsp_tag, rsp_err
  );
endinterface

// File: rtl/mult_cmd_sequencer.sv
// Queues multiplier commands, issues one at a time with stable operands, and returns
// product + tag + error code; handles illegal mode, multiplier timeout and data_valid drain.
module mult_cmd_sequencer #(
  parameter int FIFO_DEPTH  = 2,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic busy_o,
  mult_cmd_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam int ENT_W = 34 + TAG_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DRAIN} state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             cmd_ready_reg;

  state_t           state_reg;
  logic [TMO_W-1:0] tmo_reg;
  logic [15:0]      multiplicand_reg, multiplier_reg;
  logic [1:0]       cm_reg;
  logic             enable_reg;
  logic             rsp_valid_reg;
  logic [31:0]      product_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [1:0]       err_reg;

  logic             push, pop;
  logic [ENT_W-1:0] head;
  logic [15:0]      head_a, head_b;
  logic [1:0]       head_mode;
  logic [TAG_W-1:0] head_tag;

  assign push = bus.cmd_valid && cmd_ready_reg;
  assign pop  = (state_reg == IDLE) && (count_reg != '0);
  assign head = fifo_mem[rd_ptr_reg];
  assign {head_a, head_b, head_mode, head_tag} = head;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked by count_reg alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {bus.cmd_a, bus.cmd_b, bus.cmd_mode, bus.cmd_tag};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      cmd_ready_reg    <= 1'b1;
      state_reg        <= IDLE;
      tmo_reg          <= '0;
      multiplicand_reg <= '0;
      multiplier_reg   <= '0;
      cm_reg           <= '0;
      enable_reg       <= 1'b0;
      rsp_valid_reg    <= 1'b0;
      product_reg      <= '0;
      tag_reg          <= '0;
      err_reg          <= ERR_OK;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg     <= count_next;
      // Ready follows the next count, so a full FIFO never accepts even while popping.
      cmd_ready_reg <= (count_next != FULL_CNT);

      case (state_reg)
        IDLE: begin
          if (pop) begin
            multiplicand_reg <= head_a;
            multiplier_reg   <= head_b;
            cm_reg           <= head_mode;
            tag_reg          <= head_tag;
            if (head_mode == 2'b11) begin
              enable_reg    <= 1'b0;
              product_reg   <= '0;
              err_reg       <= ERR_ILLEGAL;
              rsp_valid_reg <= 1'b1;
              state_reg     <= RESP;
            end else begin
              enable_reg <= 1'b1;
              tmo_reg    <= '0;
              state_reg  <= WAIT;
            end
          end
        end
        WAIT: begin
          tmo_reg <= tmo_reg + 1'b1;
          if (bus.mul_valid) begin
            product_reg   <= bus.mul_product;
            err_reg       <= ERR_OK;
            enable_reg    <= 1'b0;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end else if (tmo_reg == TMO_LAST) begin
            product_reg   <= '0;
            err_reg       <= ERR_TIMEOUT;
            enable_reg    <= 1'b0;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            if (err_reg == ERR_ILLEGAL) begin
              state_reg <= IDLE;
            end else begin
              tmo_reg   <= '0;
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Wait for the multiplier's data_valid to fall before the next issue.
          tmo_reg <= tmo_reg + 1'b1;
          if (!bus.mul_valid || tmo_reg == TMO_LAST) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready        = cmd_ready_reg;
  assign bus.mul_multiplicand = multiplicand_reg;
  assign bus.mul_multiplier   = multiplier_reg;
  assign bus.mul_cm           = cm_reg;
  assign bus.mul_enable       = enable_reg;
  assign bus.rsp_valid        = rsp_valid_reg;
  assign bus.rsp_product      = product_reg;
  assign bus.rsp_tag          = tag_reg;
  assign bus.rsp_err          = err_reg;
  assign busy_o               = (state_reg != IDLE) || (count_reg != '0);
endmodule

// File: tb/tb_mult_cmd_sequencer.sv
// Directed bench for mult_cmd_sequencer with a behavioural Booth multiplier stand-in
// that raises data_valid a few cycles after enable (or never, when dead is set).
module tb_mult_cmd_sequencer;
  localparam int TAG_W       = 4;
  localparam int TIMEOUT_CYC = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  logic dead = 1'b0;
  logic [2:0] mul_cnt;
  int n_checks = 0;
  int n_pass = 0;

  mult_cmd_sequencer_if #(.TAG_W(TAG_W)) bus ();

  mult_cmd_sequencer #(
    .FIFO_DEPTH (2),
    .TAG_W      (TAG_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .busy_o (busy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mul_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] m);
    logic signed [7:0]  al, bl, ah, bh;
    logic signed [15:0] pl, ph, a16, b16;
    logic signed [31:0] p32;
    al = a[7:0];  bl = b[7:0];
    ah = a[15:8]; bh = b[15:8];
    pl = al * bl;
    ph = ah * bh;
    a16 = a; b16 = b;
    p32 = a16 * b16;
    case (m)
      2'b00:   return {{16{pl[15]}}, pl};
      2'b01:   return {ph, pl};
      default: return p32;
    endcase
  endfunction

  // Multiplier stand-in: data_valid after 4 enabled cycles, held until enable falls.
  always @(posedge clk) begin
    if (!bus.mul_enable) begin
      mul_cnt       <= '0;
      bus.mul_valid <= 1'b0;
    end else if (!dead) begin
      if (mul_cnt == 3'd3) begin
        bus.mul_valid   <= 1'b1;
        bus.mul_product <= mul_model(bus.mul_multiplicand, bus.mul_multiplier, bus.mul_cm);
      end else begin
        mul_cnt <= mul_cnt + 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%h expected 0x%h", name, obs, exp);
  endtask

  // Drives one command for one clock edge; starts and ends at a falling edge.
  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                      input logic [3:0] t, input bit hold);
    bus.cmd_valid = 1'b1;
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_mode = m; bus.cmd_tag = t;
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string name, input logic [31:0] prod, input logic [3:0] tag,
                            input logic [1:0] err, input int stall);
    bit got = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus.rsp_valid) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_rsp_arrived"}, 32'(got), 32'd1);
    if (got) begin
      check({name, "_product"}, bus.rsp_product, prod);
      check({name, "_tag"}, 32'(bus.rsp_tag), 32'(tag));
      check({name, "_err"}, 32'(bus.rsp_err), 32'(err));
      if (stall > 0) begin
        repeat (stall) @(negedge clk);
        check({name, "_stall_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({name, "_stall_product"}, bus.rsp_product, prod);
        check({name, "_stall_tag"}, 32'(bus.rsp_tag), 32'(tag));
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      $display("rsp %s: product=0x%h tag=%0d err=%0d", name, prod, tag, err);
    end
  endtask

  initial begin
    int cyc;
    bit en_seen;
    bit rsp_seen;
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_mode = '0; bus.cmd_tag = '0;
    bus.rsp_ready = 1'b0;

    @(posedge clk);
    @(negedge clk);
    check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("reset_enable", 32'(bus.mul_enable), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_operand", 32'(bus.mul_multiplicand), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Mode 00 with issue latency check
    push(16'h00FF, 16'h0003, 2'b00, 4'd5, 0);
    check("lat_enable_n1", 32'(bus.mul_enable), 32'd0);
    @(negedge clk);
    check("lat_enable_n2", 32'(bus.mul_enable), 32'd1);
    check("m00_multiplicand", 32'(bus.mul_multiplicand), 32'h00FF);
    check("m00_cm", 32'(bus.mul_cm), 32'd0);
    expect_rsp("m00", 32'hFFFF_FFFD, 4'd5, 2'b00, 0);

    push(16'h0302, 16'h0405, 2'b01, 4'd6, 0);
    expect_rsp("m01", 32'h000C_000A, 4'd6, 2'b00, 0);
    push(16'hFFFF, 16'h0002, 2'b10, 4'd7, 0);
    expect_rsp("m10", 32'hFFFF_FFFE, 4'd7, 2'b00, 0);
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Three back-to-back commands, consumer stalled
    push(16'h0002, 16'h0003, 2'b00, 4'd1, 1);
    push(16'h00FE, 16'h0005, 2'b00, 4'd2, 1);
    check("fifo_ready_before_third", 32'(bus.cmd_ready), 32'd1);
    push(16'h0007, 16'h0080, 2'b00, 4'd3, 0);
    check("fifo_full_ready", 32'(bus.cmd_ready), 32'd0);
    check("fifo_busy", 32'(busy), 32'd1);
    expect_rsp("q1", 32'h0000_0006, 4'd1, 2'b00, 5);
    expect_rsp("q2", 32'hFFFF_FFF6, 4'd2, 2'b00, 3);
    expect_rsp("q3", 32'hFFFF_FC80, 4'd3, 2'b00, 0);

    // Illegal mode followed by a legal command
    push(16'h1234, 16'h5678, 2'b11, 4'd9, 1);
    push(16'h0003, 16'h0004, 2'b10, 4'd10, 0);
    en_seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.rsp_valid) break;
      if (bus.mul_enable) en_seen = 1;
      @(negedge clk);
    end
    check("ill_enable_seen", 32'(en_seen), 32'd0);
    check("ill_enable_now", 32'(bus.mul_enable), 32'd0);
    expect_rsp("ill", 32'h0, 4'd9, 2'b01, 0);
    expect_rsp("after_ill", 32'h0000_000C, 4'd10, 2'b00, 0);

    // Multiplier never responds
    dead = 1'b1;
    push(16'h0011, 16'h0022, 2'b00, 4'd4, 0);
    for (int i = 0; i < 10; i++) begin
      if (bus.mul_enable) break;
      @(negedge clk);
    end
    check("tmo_enable_rose", 32'(bus.mul_enable), 32'd1);
    cyc = 0;
    while (!bus.rsp_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("tmo_cycles", 32'(cyc), 32'(TIMEOUT_CYC));
    check("tmo_enable_dropped", 32'(bus.mul_enable), 32'd0);
    expect_rsp("tmo", 32'h0, 4'd4, 2'b10, 0);
    @(negedge clk);
    check("tmo_back_idle", 32'(busy), 32'd0);

    // Reset while waiting with two commands queued
    push(16'h0001, 16'h0001, 2'b00, 4'd1, 1);
    push(16'h0002, 16'h0002, 2'b00, 4'd2, 1);
    push(16'h0003, 16'h0003, 2'b00, 4'd3, 0);
    check("rst_pre_enable", 32'(bus.mul_enable), 32'd1);
    check("rst_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_enable", 32'(bus.mul_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    dead = 1'b0;
    rsp_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.mul_enable) rsp_seen = 1;
    end
    check("rst_no_activity", 32'(rsp_seen), 32'd0);
    push(16'h0010, 16'h0010, 2'b00, 4'd12, 0);
    expect_rsp("post_rst", 32'h0000_0100, 4'd12, 2'b00, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
